// File: rtl/q_meas_avg.sv
// q_meas_avg
// ----------
// Charge-measurement front end for the secant current-reference search.
// After every new current reference it waits a fixed settling window, then
// averages 2**AVG_LOG2 ADC samples and publishes the result on measured_q
// with a one-cycle ready pulse. While en stays high it re-measures
// back to back.
//
// Handshake: adc_valid qualifies adc_data on the cycle it is high. There is
// no back-pressure toward the ADC: every valid sample seen in ACCUM is
// consumed. ready is a registered single-cycle strobe with no ready-side
// acknowledge. measured_q is valid from the ready cycle until the next
// ready.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-low reset
//   en         in   1      measurement enable (low forces IDLE)
//   i_ref      in   WIDTH  current reference, watched for changes
//   adc_valid  in   1      adc_data valid this cycle
//   adc_data   in   WIDTH  unsigned charge sample
//   measured_q out  WIDTH  averaged charge, held between measurements
//   ready      out  1      one-cycle pulse: new measured_q
//   busy       out  1      high in SETTLE or ACCUM
//   dbg_state  out  2      current FSM state (0 IDLE, 1 SETTLE, 2 ACCUM)
module q_meas_avg #(
  parameter int WIDTH    = 10,
  parameter int SETTLE   = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] i_ref,
  input  logic             adc_valid,
  input  logic [WIDTH-1:0] adc_data,
  output logic [WIDTH-1:0] measured_q,
  output logic             ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int N    = 1 << AVG_LOG2;
  localparam int CMAX = (SETTLE > N) ? SETTLE : N;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;
  // N samples of at most 2**WIDTH-1 always fit in WIDTH+AVG_LOG2 bits.
  localparam int AW   = WIDTH + AVG_LOG2;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] N_LAST      = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [AW-1:0]    acc, acc_n;
  logic [AW-1:0]    acc_sum;
  logic [WIDTH-1:0] i_ref_q;
  logic             chg;
  logic             ready_n;
  logic             q_load;

  assign chg       = (i_ref != i_ref_q);
  assign acc_sum   = acc + AW'(adc_data);
  assign dbg_state = state;

  // Priority: en low > reference change > sample accept / completion.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    ready_n = 1'b0;
    q_load  = 1'b0;
    if (!en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      acc_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A reference change while idle is irrelevant: the settle
          // window starts now regardless.
          state_n = S_SETTLE;
          cnt_n   = '0;
          acc_n   = '0;
        end
        S_SETTLE: begin
          if (chg) begin
            cnt_n = '0;
            acc_n = '0;
          end else if (cnt == SETTLE_LAST) begin
            state_n = S_ACCUM;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_ACCUM: begin
          if (chg) begin
            // Samples taken under the old reference are worthless.
            state_n = S_SETTLE;
            cnt_n   = '0;
            acc_n   = '0;
          end else if (adc_valid) begin
            if (cnt == N_LAST) begin
              state_n = S_SETTLE;
              cnt_n   = '0;
              acc_n   = '0;
              ready_n = 1'b1;
              q_load  = 1'b1;
            end else begin
              acc_n = acc_sum;
              cnt_n = cnt + CW'(1);
            end
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
          acc_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      acc        <= '0;
      i_ref_q    <= '0;
      measured_q <= '0;
      ready      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt     <= cnt_n;
      acc     <= acc_n;
      i_ref_q <= i_ref;
      ready   <= ready_n;
      busy    <= (state_n != S_IDLE);
      if (q_load) begin
        // Truncating divide by N: take the top WIDTH bits of the sum.
        measured_q <= acc_sum[AW-1 -: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_q_meas_avg.sv
module tb_q_meas_avg;

  localparam int WIDTH    = 10;
  localparam int SETTLE   = 4;
  localparam int AVG_LOG2 = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] i_ref;
  logic             adc_valid;
  logic [WIDTH-1:0] adc_data;
  logic [WIDTH-1:0] measured_q;
  logic             ready;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  q_meas_avg #(
    .WIDTH   (WIDTH),
    .SETTLE  (SETTLE),
    .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .i_ref     (i_ref),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .measured_q(measured_q),
    .ready     (ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one sample, let one rising edge consume it, then settle 1 time
  // unit so outputs reflect that edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input logic v, input logic [WIDTH-1:0] d, input logic exp_rdy);
    step(v, d);
    check("ready", {31'd0, ready}, {31'd0, exp_rdy});
  endtask

  logic             sp_v [7];
  logic [WIDTH-1:0] sp_d [7];

  initial begin
    rst = 1'b0; en = 1'b0; i_ref = '0; adc_valid = 1'b0; adc_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_q", {22'd0, measured_q}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    rst = 1'b1;
    step(1'b0, '0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // ---- basic average: E0 enter SETTLE, E1..E4 settle, E5..E8 samples
    en = 1'b1;
    step_chk(1'b0, '0, 1'b0);                       // E0
    check("e0_busy", {31'd0, busy}, 32'd1);
    check("e0_state", {30'd0, dbg_state}, 32'd1);
    for (int k = 1; k <= 4; k++) step_chk(1'b1, 10'd999, 1'b0); // ignored while settling
    check("accum_state", {30'd0, dbg_state}, 32'd2);
    step_chk(1'b1, 10'd100, 1'b0);
    step_chk(1'b1, 10'd101, 1'b0);
    step_chk(1'b1, 10'd102, 1'b0);
    step_chk(1'b1, 10'd103, 1'b1);                  // E8
    check("basic_q", {22'd0, measured_q}, 32'd101);

    // ---- full scale, back to back: E9..E16, ready only at E16
    for (int e = 9; e <= 16; e++) begin
      step_chk(1'b1, 10'd1023, (e == 16));
      if (e == 9) check("hold_q", {22'd0, measured_q}, 32'd101);
    end
    check("full_q", {22'd0, measured_q}, 32'd1023);

    // ---- sparse: E17..E20 settle, pattern 1,0,0,1,1,0,1 on E21..E27
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0);
    sp_v[0] = 1; sp_v[1] = 0; sp_v[2] = 0; sp_v[3] = 1; sp_v[4] = 1; sp_v[5] = 0; sp_v[6] = 1;
    sp_d[0] = 10'd200; sp_d[1] = 10'd1023; sp_d[2] = 10'd1023; sp_d[3] = 10'd201;
    sp_d[4] = 10'd202; sp_d[5] = 10'd1023; sp_d[6] = 10'd207;
    for (int k = 0; k < 7; k++) step_chk(sp_v[k], sp_d[k], (k == 6));
    check("sparse_q", {22'd0, measured_q}, 32'd202);   // 810 >> 2

    // ---- reference change after 2 samples: E28..E31 settle, E32/E33 samples
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0);
    step_chk(1'b1, 10'd10, 1'b0);
    step_chk(1'b1, 10'd20, 1'b0);
    i_ref = 10'd5;
    step_chk(1'b1, 10'd30, 1'b0);                   // E34: change detected
    check("chg_busy", {31'd0, busy}, 32'd1);
    check("chg_state", {30'd0, dbg_state}, 32'd1);
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0); // E35..E38
    check("chg_busy2", {31'd0, busy}, 32'd1);
    step_chk(1'b1, 10'd40, 1'b0);
    step_chk(1'b1, 10'd40, 1'b0);
    step_chk(1'b1, 10'd40, 1'b0);
    step_chk(1'b1, 10'd44, 1'b1);                   // E42 = E34 + 8
    check("chg_q", {22'd0, measured_q}, 32'd41);    // 164 >> 2, no stale samples

    // ---- change coincident with 4th sample: E43..E46 settle, E47..E50
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0);
    for (int k = 0; k < 3; k++) step_chk(1'b1, 10'd7, 1'b0);
    i_ref = 10'd6;
    step_chk(1'b1, 10'd7, 1'b0);                    // E50: discarded
    check("coinc_q", {22'd0, measured_q}, 32'd41);
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0);
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd8, (k == 3)); // E58
    check("coinc_q2", {22'd0, measured_q}, 32'd8);

    // ---- secant handshake: i_ref moves the cycle after ready (E59)
    i_ref = 10'd7;
    step_chk(1'b0, 10'd0, 1'b0);                    // E59: restart settle
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0); // E60..E63
    step_chk(1'b1, 10'd1, 1'b0);
    step_chk(1'b1, 10'd2, 1'b0);
    step_chk(1'b1, 10'd3, 1'b0);
    step_chk(1'b1, 10'd4, 1'b1);                    // E67
    check("secant_q", {22'd0, measured_q}, 32'd2);  // 10 >> 2

    // ---- enable drop in ACCUM: E68..E71 settle, E72/E73 samples, E74 drop
    for (int k = 0; k < 4; k++) step_chk(1'b1, 10'd0, 1'b0);
    step_chk(1'b1, 10'd50, 1'b0);
    step_chk(1'b1, 10'd50, 1'b0);
    en = 1'b0;
    step_chk(1'b1, 10'd50, 1'b0);                   // E74
    check("drop_busy", {31'd0, busy}, 32'd0);
    check("drop_state", {30'd0, dbg_state}, 32'd0);
    check("drop_q", {22'd0, measured_q}, 32'd2);
    step_chk(1'b1, 10'd50, 1'b0);
    step_chk(1'b1, 10'd50, 1'b0);
    check("idle_busy2", {31'd0, busy}, 32'd0);
    // re-enable together with an i_ref change, which IDLE ignores
    en = 1'b1;
    i_ref = 10'd9;
    for (int k = 0; k <= 8; k++) step_chk(1'b1, 10'd500, (k == 8));
    check("reen_q", {22'd0, measured_q}, 32'd500);

    // ---- asynchronous reset mid-run, right after a ready pulse
    rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_q", {22'd0, measured_q}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      logic [WIDTH-1:0] d;
      d = (k >= 5) ? WIDTH'(55 + k) : '0;           // 60,61,62,63 on E5..E8
      step_chk(1'b1, d, (k == 8));
    end
    check("post_rst_q", {22'd0, measured_q}, 32'd61); // 246 >> 2
    step_chk(1'b1, 10'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
